// File: rtl/ov7670_sccb_config_if.sv
// SCCB configuration bus: start strobe, registered table ROM port, SIOC/SIOD pins and status.
interface ov7670_sccb_config_if;
    logic        START;
    logic [7:0]  TBL_ADDR;
    logic [15:0] TBL_DATA;
    logic        SIOC;
    logic        SIOD_OE;
    logic        BUSY;
    logic        DONE;
    logic [7:0]  REG_COUNT;

    modport master (
        input  START,
        input  TBL_DATA,
        output TBL_ADDR,
        output SIOC,
        output SIOD_OE,
        output BUSY,
        output DONE,
        output REG_COUNT
    );

    modport slave (
        output START,
        output TBL_DATA,
        input  TBL_ADDR,
        input  SIOC,
        input  SIOD_OE,
        input  BUSY,
        input  DONE,
        input  REG_COUNT
    );
endinterface

// File: rtl/ov7670_sccb_config.sv
// OV7670 power-up configurator: walks a {reg, val} table and issues SCCB 3-phase writes.
// Entries 16'hFFFF (end of table) and 16'hFFF0 (fixed delay) are control markers.
module ov7670_sccb_config #(
    parameter int unsigned CLK_FREQ_HZ  = 12_000_000,
    parameter int unsigned SCCB_FREQ_HZ = 100_000,
    parameter logic [7:0]  DEVICE_ID    = 8'h42,
    parameter int unsigned DELAY_CYCLES = 120_000
) (
    input logic                  CLK,
    input logic                  RESET_N,
    ov7670_sccb_config_if.master bus
);

    localparam int unsigned QDIV  = CLK_FREQ_HZ / (4 * SCCB_FREQ_HZ);
    localparam int unsigned DIV_W = (QDIV > 1) ? $clog2(QDIV) : 1;
    localparam int unsigned DLY_W = (DELAY_CYCLES > 1) ? $clog2(DELAY_CYCLES) : 1;

    if (QDIV < 2) begin : g_qdiv_check
        $error("ov7670_sccb_config: CLK_FREQ_HZ/(4*SCCB_FREQ_HZ) must be at least 2");
    end
    if (DELAY_CYCLES < 1) begin : g_delay_check
        $error("ov7670_sccb_config: DELAY_CYCLES must be at least 1");
    end

    localparam logic [3:0] StIdle   = 4'd0;
    localparam logic [3:0] StFetch  = 4'd1;
    localparam logic [3:0] StDecode = 4'd2;
    localparam logic [3:0] StStartC = 4'd3;
    localparam logic [3:0] StBits   = 4'd4;
    localparam logic [3:0] StStopC  = 4'd5;
    localparam logic [3:0] StGap    = 4'd6;
    localparam logic [3:0] StWait   = 4'd7;
    localparam logic [3:0] StFinish = 4'd8;

    localparam logic [15:0] EndMarker   = 16'hFFFF;
    localparam logic [15:0] DelayMarker = 16'hFFF0;

    logic [3:0]       state_q, state_d;
    logic [DIV_W-1:0] div_q, div_d;
    logic [1:0]       quarter_q, quarter_d;
    logic [4:0]       bit_q, bit_d;
    logic [26:0]      shift_q, shift_d;
    logic [DLY_W-1:0] delay_q, delay_d;
    logic [7:0]       tbl_addr_q, tbl_addr_d;
    logic [7:0]       reg_count_q, reg_count_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             sioc_q, sioc_d;
    logic             siod_oe_q, siod_oe_d;

    logic tick;
    logic phase_end;
    logic in_phase;

    // Pin levels for a given bus position, returned as {sioc, siod_oe}.
    function automatic logic [1:0] bus_drive(input logic [3:0] st, input logic [1:0] q,
                                             input logic b);
        case (st)
            StStartC: bus_drive = {1'b1, q != 2'd0};
            StBits:   bus_drive = {q[1], ~b};
            StStopC:  bus_drive = {q[1], q != 2'd3};
            default:  bus_drive = 2'b10;
        endcase
    endfunction

    assign tick      = (div_q == DIV_W'(QDIV - 1));
    assign phase_end = tick && (quarter_q == 2'd3);
    assign in_phase  = (state_q == StStartC) || (state_q == StBits) ||
                       (state_q == StStopC)  || (state_q == StGap);

    always_comb begin
        state_d     = state_q;
        div_d       = div_q;
        quarter_d   = quarter_q;
        bit_d       = bit_q;
        shift_d     = shift_q;
        delay_d     = delay_q;
        tbl_addr_d  = tbl_addr_q;
        reg_count_d = reg_count_q;
        busy_d      = busy_q;
        done_d      = done_q;

        if (in_phase) begin
            div_d = tick ? '0 : div_q + 1'b1;
            if (tick) begin
                quarter_d = quarter_q + 2'd1;
            end
        end

        case (state_q)
            StIdle: begin
                if (bus.START) begin
                    state_d     = StFetch;
                    busy_d      = 1'b1;
                    done_d      = 1'b0;
                    reg_count_d = '0;
                    tbl_addr_d  = '0;
                end
            end
            StFetch: state_d = StDecode;
            StDecode: begin
                if (bus.TBL_DATA == EndMarker) begin
                    state_d = StFinish;
                end else if (bus.TBL_DATA == DelayMarker) begin
                    state_d = StWait;
                    delay_d = '0;
                end else begin
                    state_d   = StStartC;
                    div_d     = '0;
                    quarter_d = '0;
                    bit_d     = '0;
                    // The 1 after each byte releases SIOD for the don't-care (ACK) bit.
                    shift_d   = {DEVICE_ID, 1'b1, bus.TBL_DATA[15:8], 1'b1,
                                 bus.TBL_DATA[7:0], 1'b1};
                end
            end
            StStartC: begin
                if (phase_end) begin
                    state_d = StBits;
                end
            end
            StBits: begin
                if (phase_end) begin
                    shift_d = {shift_q[25:0], 1'b0};
                    if (bit_q == 5'd26) begin
                        state_d = StStopC;
                    end else begin
                        bit_d = bit_q + 5'd1;
                    end
                end
            end
            StStopC: begin
                if (phase_end) begin
                    state_d = StGap;
                end
            end
            StGap: begin
                if (phase_end) begin
                    if (reg_count_q != 8'hFF) begin
                        reg_count_d = reg_count_q + 8'd1;
                    end
                    if (tbl_addr_q == 8'hFF) begin
                        state_d = StFinish;
                    end else begin
                        tbl_addr_d = tbl_addr_q + 8'd1;
                        state_d    = StFetch;
                    end
                end
            end
            StWait: begin
                if (delay_q == DLY_W'(DELAY_CYCLES - 1)) begin
                    if (tbl_addr_q == 8'hFF) begin
                        state_d = StFinish;
                    end else begin
                        tbl_addr_d = tbl_addr_q + 8'd1;
                        state_d    = StFetch;
                    end
                end else begin
                    delay_d = delay_q + 1'b1;
                end
            end
            StFinish: begin
                busy_d  = 1'b0;
                done_d  = 1'b1;
                state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase

        // Pins are registered from the next bus position so they never glitch.
        {sioc_d, siod_oe_d} = bus_drive(state_d, quarter_d, shift_d[26]);
    end

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            state_q     <= StIdle;
            div_q       <= '0;
            quarter_q   <= '0;
            bit_q       <= '0;
            shift_q     <= '0;
            delay_q     <= '0;
            tbl_addr_q  <= '0;
            reg_count_q <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            sioc_q      <= 1'b1;
            siod_oe_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            div_q       <= div_d;
            quarter_q   <= quarter_d;
            bit_q       <= bit_d;
            shift_q     <= shift_d;
            delay_q     <= delay_d;
            tbl_addr_q  <= tbl_addr_d;
            reg_count_q <= reg_count_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            sioc_q      <= sioc_d;
            siod_oe_q   <= siod_oe_d;
        end
    end

    assign bus.TBL_ADDR  = tbl_addr_q;
    assign bus.SIOC      = sioc_q;
    assign bus.SIOD_OE   = siod_oe_q;
    assign bus.BUSY      = busy_q;
    assign bus.DONE      = done_q;
    assign bus.REG_COUNT = reg_count_q;

endmodule

// File: doc/ov7670_sccb_config.md
# ov7670_sccb_config

Power-up configuration controller for the OV7670 camera on the iCE40 UltraPlus. On a START pulse it walks a register table of {sub-address, value} entries and writes each entry to the camera over SCCB as 3-phase write transactions. It owns the SIOC/SIOD pins and raises DONE when the sensor is configured. The pixel-capture path (PIXEL/VSYNC/HREF/PCLK) must not trust the camera image until DONE is high.

## Interface
- CLK_FREQ_HZ, 12_000_000: CLK frequency.
- SCCB_FREQ_HZ, 100_000: SIOC frequency.
- DEVICE_ID, 8'h42: SCCB write ID byte.
- DELAY_CYCLES, 120_000: wait length for a delay marker (10 ms at 12 MHz).
- Derived: QDIV = CLK_FREQ_HZ/(4*SCCB_FREQ_HZ), the CLK cycles per quarter-bit. QDIV must be ≥ 2 (elaboration error otherwise).

- CLK  in  1  system clock.
- RESET_N  in  1  asynchronous, active-low reset.
- START  in  1  one-cycle pulse that begins a configuration pass.
- TBL_ADDR  out  8  table index.
- TBL_DATA  in  16  entry {reg[15:8], val[7:0]}, valid 1 cycle after TBL_ADDR (registered ROM).
- SIOC  out  1  SCCB clock, push-pull.
- SIOD_OE  out  1  1 = drive SIOD low, 0 = release (pull-up).
- BUSY  out  1  pass in progress.
- DONE  out  1  pass complete; held until next START.
- REG_COUNT  out  8  SCCB writes completed this pass.

## Operation
- States: IDLE, FETCH, DECODE, START_C, BITS, STOP_C, GAP, WAIT, FINISH.
- IDLE: SIOC=1, SIOD_OE=0. START moves to FETCH, sets BUSY=1, clears DONE, REG_COUNT=0, TBL_ADDR=0.
- FETCH: hold for 1 cycle while the ROM responds, then go to DECODE.
- DECODE examines TBL_DATA:
  - 16'hFFFF is the end marker: go to FINISH.
  - 16'hFFF0 is the delay marker: go to WAIT, count DELAY_CYCLES, then TBL_ADDR+1 and FETCH.
  - Anything else: load a 27-bit shift register {DEVICE_ID,1'b1, reg,1'b1, val,1'b1} and go to START_C.
- Bits 9, 18 and 27 are don't-care bits. Their SIOD_OE is 0 (released). ACK is not checked.
- START_C: 4 quarters with SIOC=1. SIOD_OE=1 from quarter 1 on.
- BITS: 27 bits, MSB first, 4 quarters each:
  - Q0: SIOC=0; SIOD_OE = ~bit.
  - Q1: SIOC=0.
  - Q2 and Q3: SIOC=1.
- STOP_C: 4 quarters.
  - Q0–Q1: SIOC=0, SIOD_OE=1.
  - Q2: SIOC=1.
  - Q3: SIOD_OE=0.
- GAP: 4 quarters of bus idle. Then REG_COUNT+1.
  - If TBL_ADDR==255: go to FINISH (no wrap; the table is capped at 256 entries).
  - Else TBL_ADDR+1 and FETCH.
- FINISH: BUSY=0, DONE=1, go to IDLE.
- START while BUSY is ignored. START while DONE=1 restarts the pass from index 0.
- REG_COUNT saturates at 255. Delay and end markers are not counted.

## Timing
- Reset values (asynchronous, immediate): SIOC=1, SIOD_OE=0, BUSY=0, DONE=0, TBL_ADDR=0, REG_COUNT=0, state IDLE.
- Reset mid-transaction returns the bus to idle with no stop condition. The camera resynchronises on the next start condition.
- BUSY rises the cycle after START is sampled. SIOD_OE first rises 3+QDIV cycles after START is sampled.
- One write occupies exactly 120 quarters (4 + 108 + 4 + 4), i.e. 120*QDIV cycles, plus 2 cycles of FETCH/DECODE.
- Delay entry cost: 2 + DELAY_CYCLES cycles.
- End marker: DONE rises 3 cycles after FETCH of the marker index.
- SIOD_OE changes only while SIOC=0, except during the start and stop conditions.

## Test plan
- Reset: assert RESET_N=0 mid-bit -> SIOC=1, SIOD_OE=0, BUSY=0, DONE=0, REG_COUNT=0 within the same cycle. After release with no START, the bus stays idle.
- Single write, QDIV=2 (CLK_FREQ_HZ=800, SCCB_FREQ_HZ=100), table {16'h1280, 16'hFFFF} -> sampling SIOD on SIOC rising edges yields 0x42,Z,0x12,Z,0x80,Z. DONE rises 2+240+3 cycles after BUSY. REG_COUNT=1.
- Delay marker, DELAY_CYCLES=50, table {16'h1280, 16'hFFF0, 16'h1104, 16'hFFFF} -> exactly 52 idle cycles between the first GAP end and the second FETCH. REG_COUNT=2.
- START pulsed while BUSY -> ignored, same waveform as with no pulse. START after DONE -> DONE clears next cycle and the pass repeats from TBL_ADDR=0.
- 256 entries with no end marker -> TBL_ADDR stops at 255, DONE=1, REG_COUNT=255 (saturated), no wrap to 0.
- Bus protocol checker across all tests: no SIOD transition while SIOC=1 other than start/stop. SIOC high and low each last 2*QDIV cycles.
